// File: rtl/dcache_pkg.sv
// Shared types and constants for the MEM-stage L1 data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  localparam int WORDS_PER_LINE = 4;
  localparam int BLOCK_W        = 128;
  localparam int ADDR_W         = 30;
  localparam int MEM_ADDR_W     = 28;

endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage for the direct-mapped data cache.
// One combinational read port, one word-write port (sets dirty) and one
// block-fill port (sets valid, loads tag, clears dirty). Only valid and dirty
// are cleared by reset; tag and data contents are left as they are.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int TAG_W     = 25,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [1:0]         wr_off,
  input  logic [31:0]        wr_word,
  input  logic               fill_en,
  input  logic [IDX_W-1:0]   fill_idx,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_data
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];
  logic [BLOCK_W-1:0]   data_d [NUM_LINES];

  // Read port: purely combinational so hits complete in the request cycle.
  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_dirty = dirty_q[rd_idx];
    rd_tag   = tag_q[rd_idx];
    rd_data  = data_q[rd_idx];
  end

  // Next-state of the storage: word store marks the line dirty, block fill
  // installs a clean valid line.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      data_d[wr_idx][{wr_off, 5'd0} +: 32] = wr_word;
      dirty_d[wr_idx] = 1'b1;
    end
    if (fill_en) begin
      data_d[fill_idx]  = fill_data;
      tag_d[fill_idx]   = fill_tag;
      valid_d[fill_idx] = 1'b1;
      dirty_d[fill_idx] = 1'b0;
    end
  end

  // Status bits reset synchronously; the line contents do not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays are plain storage without reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/mem_dcache.sv
// L1 data cache controller: direct-mapped, write-back, write-allocate.
// Holds the miss FSM and the registered block-memory request outputs.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | serve hits combinationally; launch writeback or fetch on miss
// WRITEBACK | dirty victim on mem_wdata, waiting for mem_ready
// ALLOCATE  | block fetch outstanding, waiting for mem_ready to fill line
module mem_dcache
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int TAG_W     = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  proc_read,
  input  logic                  proc_write,
  input  logic [ADDR_W-1:0]     proc_addr,
  input  logic [31:0]           proc_wdata,
  output logic [31:0]           proc_rdata,
  output logic                  proc_stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [BLOCK_W-1:0]    mem_wdata,
  input  logic [BLOCK_W-1:0]    mem_rdata,
  input  logic                  mem_ready
);

  localparam int IDX_W = $clog2(NUM_LINES);

  state_e                state_q, state_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic [1:0]         req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               line_valid, line_dirty, hit, req;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_data;
  logic               wr_en, fill_en;

  assign req_off = proc_addr[1:0];
  assign req_idx = proc_addr[1+IDX_W:2];
  assign req_tag = proc_addr[ADDR_W-1:2+IDX_W];

  dcache_line_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .IDX_W     (IDX_W)
  ) u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (req_idx),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (wr_en),
    .wr_idx    (req_idx),
    .wr_off    (req_off),
    .wr_word   (proc_wdata),
    .fill_en   (fill_en),
    .fill_idx  (req_idx),
    .fill_tag  (req_tag),
    .fill_data (mem_rdata)
  );

  // Hit detection, load data select, stall and storage write strobes.
  // A store wins over a load, and nothing is written while reset is held.
  always_comb begin
    req        = proc_read | proc_write;
    hit        = line_valid && (line_tag == req_tag);
    proc_rdata = line_data[{req_off, 5'd0} +: 32];
    wr_en      = rst_n && (state_q == IDLE) && proc_write && hit;
    fill_en    = rst_n && (state_q == ALLOCATE) && mem_ready;
    if (!rst_n)
      proc_stall = 1'b0;
    else if (state_q == IDLE)
      proc_stall = req && !hit;
    else
      proc_stall = 1'b1;
  end

  // Miss sequencing: next state and next memory-request register values.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          if (line_valid && line_dirty) begin
            state_d     = WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {line_tag, req_idx};
            mem_wdata_d = line_data;
          end else begin
            state_d    = ALLOCATE;
            mem_read_d = 1'b1;
            mem_addr_d = proc_addr[ADDR_W-1:2];
          end
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          state_d     = ALLOCATE;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = proc_addr[ADDR_W-1:2];
        end
      end
      ALLOCATE: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_read_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered memory-side outputs; reset abandons any miss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_dcache.sv
// Directed bench for mem_dcache: hit vectors from a table plus hand-written
// miss, writeback, reset and long-wait sequences.
module tb_mem_dcache;
  import dcache_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [127:0] BLK_D = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
  localparam logic [127:0] BLK_E = {32'hE3E3_0003, 32'hE2E2_0002, 32'hE1E1_0001, 32'hE0E0_0000};
  localparam logic [127:0] BLK_F = {32'hF3F3_0003, 32'hF2F2_0002, 32'hF1F1_0001, 32'hF0F0_0000};

  mem_dcache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd);
    proc_read  = rd;
    proc_write = wd === 32'hx ? 1'b0 : wr;
    proc_addr  = a;
    proc_wdata = wd;
    #1;
  endtask

  // Pulse mem_ready for exactly one sampling edge with the given block.
  task automatic mem_answer(input logic [127:0] blk);
    mem_rdata = blk;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
  endtask

  initial begin
    tbl[0] = '{rd:1'b1, wr:1'b0, addr:30'h10, wdata:32'h0,         exp_stall:1'b0, exp_rdata:32'hD0D0_0000};
    tbl[1] = '{rd:1'b1, wr:1'b0, addr:30'h12, wdata:32'h0,         exp_stall:1'b0, exp_rdata:32'hD2D2_0002};
    tbl[2] = '{rd:1'b1, wr:1'b0, addr:30'h13, wdata:32'h0,         exp_stall:1'b0, exp_rdata:32'hD3D3_0003};
    tbl[3] = '{rd:1'b0, wr:1'b1, addr:30'h11, wdata:32'hDEADBEEF,  exp_stall:1'b0, exp_rdata:32'h0};
    tbl[4] = '{rd:1'b1, wr:1'b0, addr:30'h11, wdata:32'h0,         exp_stall:1'b0, exp_rdata:32'hDEADBEEF};
    tbl[5] = '{rd:1'b1, wr:1'b0, addr:30'h10, wdata:32'h0,         exp_stall:1'b0, exp_rdata:32'hD0D0_0000};
    tbl[6] = '{rd:1'b0, wr:1'b0, addr:30'h0,  wdata:32'h0,         exp_stall:1'b0, exp_rdata:32'h0};
    tbl[7] = '{rd:1'b1, wr:1'b0, addr:30'h13, wdata:32'h0,         exp_stall:1'b0, exp_rdata:32'hD3D3_0003};

    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    req(1'b1, 1'b0, 30'h10, 32'h0);
    chk("stall_forced_low_in_reset", {127'b0, proc_stall}, 128'd0);
    tick(); tick();
    chk("reset_mem_read", {127'b0, mem_read}, 128'd0);
    chk("reset_mem_write", {127'b0, mem_write}, 128'd0);
    chk("reset_mem_addr", {100'b0, mem_addr}, 128'd0);
    chk("reset_mem_wdata", mem_wdata, 128'd0);
    rst_n = 1'b1;
    req(1'b0, 1'b0, 30'h0, 32'h0);
    tick();

    // mem_ready in IDLE must not start anything.
    mem_answer(BLK_E);
    chk("idle_ready_ignored_rd", {127'b0, mem_read}, 128'd0);
    chk("idle_ready_ignored_wr", {127'b0, mem_write}, 128'd0);

    // Clean miss at 0x10, memory answers 3 cycles after the request.
    req(1'b1, 1'b0, 30'h10, 32'h0);
    chk("miss_stall", {127'b0, proc_stall}, 128'd1);
    tick();
    chk("miss_mem_read", {127'b0, mem_read}, 128'd1);
    chk("miss_mem_addr", {100'b0, mem_addr}, 128'h4);
    chk("miss_mem_write", {127'b0, mem_write}, 128'd0);
    tick();
    chk("alloc_stall_1", {127'b0, proc_stall}, 128'd1);
    tick();
    chk("alloc_stall_2", {127'b0, proc_stall}, 128'd1);
    mem_answer(BLK_D);
    chk("fill_rdata_d0", {96'b0, proc_rdata}, {96'b0, 32'hD0D0_0000});
    chk("fill_stall_low", {127'b0, proc_stall}, 128'd0);
    chk("fill_mem_read_low", {127'b0, mem_read}, 128'd0);

    // Hit vectors: each applied for one cycle, stores land at the edge.
    for (int i = 0; i < 8; i++) begin
      req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("tbl%0d_stall", i), {127'b0, proc_stall}, {127'b0, tbl[i].exp_stall});
      if (tbl[i].rd && !tbl[i].wr)
        chk($sformatf("tbl%0d_rdata", i), {96'b0, proc_rdata}, {96'b0, tbl[i].exp_rdata});
      tick();
    end

    // Dirty miss: 0x111 shares index 4 with the dirty tag-0 line.
    req(1'b1, 1'b0, 30'h111, 32'h0);
    chk("dirty_miss_stall", {127'b0, proc_stall}, 128'd1);
    tick();
    chk("wb_mem_write", {127'b0, mem_write}, 128'd1);
    chk("wb_mem_read", {127'b0, mem_read}, 128'd0);
    chk("wb_mem_addr", {100'b0, mem_addr}, 128'h4);
    chk("wb_word1", {96'b0, mem_wdata[63:32]}, {96'b0, 32'hDEADBEEF});
    // Memory holds off for 50 cycles; everything must stay frozen.
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("hold_mem_write", {127'b0, mem_write}, 128'd1);
      chk("hold_mem_read", {127'b0, mem_read}, 128'd0);
      chk("hold_mem_addr", {100'b0, mem_addr}, 128'h4);
      chk("hold_mem_wdata", mem_wdata, {32'hD3D3_0003, 32'hD2D2_0002, 32'hDEADBEEF, 32'hD0D0_0000});
      chk("hold_stall", {127'b0, proc_stall}, 128'd1);
    end
    mem_answer(128'h0);
    chk("wb_done_mem_write", {127'b0, mem_write}, 128'd0);
    chk("wb_done_mem_read", {127'b0, mem_read}, 128'd1);
    chk("wb_done_mem_addr", {100'b0, mem_addr}, 128'h44);
    chk("wb_done_stall", {127'b0, proc_stall}, 128'd1);
    mem_answer(BLK_E);
    chk("refill_rdata_e1", {96'b0, proc_rdata}, {96'b0, 32'hE1E1_0001});
    chk("refill_stall", {127'b0, proc_stall}, 128'd0);

    // 0x10 now misses on a clean line; reset while the fetch is pending.
    req(1'b1, 1'b0, 30'h10, 32'h0);
    chk("evicted_miss_stall", {127'b0, proc_stall}, 128'd1);
    tick();
    chk("clean_victim_mem_read", {127'b0, mem_read}, 128'd1);
    chk("clean_victim_mem_write", {127'b0, mem_write}, 128'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_stall_low", {127'b0, proc_stall}, 128'd0);
    tick();
    chk("mid_reset_mem_read", {127'b0, mem_read}, 128'd0);
    chk("mid_reset_mem_addr", {100'b0, mem_addr}, 128'd0);
    rst_n = 1'b1;
    req(1'b1, 1'b0, 30'h111, 32'h0);
    chk("after_reset_old_hit_misses", {127'b0, proc_stall}, 128'd1);
    tick();
    chk("after_reset_fetch", {127'b0, mem_read}, 128'd1);
    chk("after_reset_fetch_addr", {100'b0, mem_addr}, 128'h44);
    mem_answer(BLK_F);
    chk("after_reset_fill", {96'b0, proc_rdata}, {96'b0, 32'hF1F1_0001});

    // Read and write together on a hit behave as a store.
    req(1'b1, 1'b1, 30'h111, 32'h1234_5678);
    chk("rw_hit_stall", {127'b0, proc_stall}, 128'd0);
    tick();
    req(1'b1, 1'b0, 30'h111, 32'h0);
    chk("rw_stored_word", {96'b0, proc_rdata}, {96'b0, 32'h1234_5678});
    tick();
    req(1'b1, 1'b0, 30'h10, 32'h0);
    tick();
    chk("rw_set_dirty_wb", {127'b0, mem_write}, 128'd1);
    chk("rw_wb_addr", {100'b0, mem_addr}, 128'h44);
    chk("rw_wb_word1", {96'b0, mem_wdata[63:32]}, {96'b0, 32'h1234_5678});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
